// File: rtl/gmm_subtract_w_sort_pipe_pkg.sv
// Shared GMM pixel/cluster record types used by the weight-sort pipeline.
// mega_data_t is 153 bits wide; the sorter's DATA_WIDTH parameter must agree.
package gmm_structures;

  localparam int GMM_CLUSTERS = 3;
  localparam int PIX_W        = 6;
  localparam int W_W          = 16;
  localparam int VAR_W        = 8;
  localparam int COLOR_W      = 8;
  localparam int IDX_W        = 2;
  localparam int B_W          = 2;

  typedef logic [IDX_W-1:0] cidx_t;

  typedef struct packed {
    logic [PIX_W-1:0] pixel;
    logic [1:0]       clusters_num;
  } data_t;

  typedef struct packed {
    data_t                                 in;
    logic [GMM_CLUSTERS-1:0][W_W-1:0]     mem_w;
    logic [GMM_CLUSTERS-1:0][VAR_W-1:0]   mem_var;
    logic [GMM_CLUSTERS-1:0][COLOR_W-1:0] mem_color;
    logic [GMM_CLUSTERS-1:0][VAR_W-1:0]   vars;
    cidx_t                                 var_min_idx;
    cidx_t                                 var_max_idx;
    cidx_t                                 p_max_idx;
    logic [VAR_W-1:0]                      var_min;
    logic [VAR_W-1:0]                      var_max;
    logic                                  is_matched;
    logic [B_W-1:0]                        B;
  } mega_data_t;

endpackage

// File: rtl/gmm_subtract_w_sort_pipe_if.sv
// Valid/ready stream carrying one mega_data_t beat per transfer.
interface gmm_subtract_w_sort_pipe_if;
  import gmm_structures::*;

  logic       valid;
  logic       ready;
  mega_data_t data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/gmm_subtract_w_sort_pipe_cas.sv
// One registered compare-and-swap on cluster slots (I,J), with its own valid/ready.
// Heavier live cluster moves to slot I; cluster-index fields follow the swap.
module gmm_subtract_cas_stage
  import gmm_structures::*;
#(
  parameter int I = 0,
  parameter int J = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid_i,
  input  mega_data_t in_data_i,
  output logic       in_ready_o,
  output logic       out_valid_o,
  output mega_data_t out_data_o,
  input  logic       out_ready_i
);

  localparam cidx_t I_IDX = cidx_t'(I);
  localparam cidx_t J_IDX = cidx_t'(J);

  logic       valid_q;
  mega_data_t data_q;
  mega_data_t data_d;
  logic       swap;

  function automatic cidx_t remap(input cidx_t idx);
    if (idx == I_IDX)      remap = J_IDX;
    else if (idx == J_IDX) remap = I_IDX;
    else                   remap = idx;
  endfunction

  // Strict compare keeps equal weights in place, which makes the network stable.
  assign swap = (I_IDX < in_data_i.in.clusters_num) &&
                (J_IDX < in_data_i.in.clusters_num) &&
                (in_data_i.mem_w[J] > in_data_i.mem_w[I]);

  always_comb begin
    data_d = in_data_i;
    if (swap) begin
      data_d.mem_w[I]     = in_data_i.mem_w[J];
      data_d.mem_w[J]     = in_data_i.mem_w[I];
      data_d.mem_var[I]   = in_data_i.mem_var[J];
      data_d.mem_var[J]   = in_data_i.mem_var[I];
      data_d.mem_color[I] = in_data_i.mem_color[J];
      data_d.mem_color[J] = in_data_i.mem_color[I];
      data_d.vars[I]      = in_data_i.vars[J];
      data_d.vars[J]      = in_data_i.vars[I];
      data_d.var_min_idx  = remap(in_data_i.var_min_idx);
      data_d.var_max_idx  = remap(in_data_i.var_max_idx);
      data_d.p_max_idx    = remap(in_data_i.p_max_idx);
    end
  end

  assign in_ready_o = out_ready_i | ~valid_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready_o) begin
      valid_q <= in_valid_i;
      // Bubbles advance the valid flag only, so held data is never clobbered.
      if (in_valid_i) data_q <= data_d;
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/gmm_subtract_w_sort_pipe.sv
// Three-stage sorting network ordering each pixel's live GMM clusters by weight,
// heaviest first: CAS (0,1), then (1,2), then (0,1).
module gmm_subtract_w_sort_pipe
  import gmm_structures::*;
#(
  parameter int DATA_WIDTH = 153
) (
  input logic                            clk,
  input logic                            rst,
  gmm_subtract_w_sort_pipe_if.slave      snk,
  gmm_subtract_w_sort_pipe_if.master     src
);

  if (DATA_WIDTH != $bits(mega_data_t)) begin : g_width_check
    $error("DATA_WIDTH does not match mega_data_t");
  end

  logic       stage_valid [4];
  logic       stage_ready [4];
  mega_data_t stage_data  [4];

  assign stage_valid[0] = snk.valid;
  assign stage_data[0]  = snk.data;
  assign snk.ready      = stage_ready[0];

  assign stage_ready[3] = src.ready;
  assign src.valid      = stage_valid[3];
  assign src.data       = stage_data[3];

  for (genvar gi = 0; gi < 3; gi++) begin : g_stage
    localparam int PAIR_I = (gi == 1) ? 1 : 0;

    gmm_subtract_cas_stage #(
      .I (PAIR_I),
      .J (PAIR_I + 1)
    ) u_cas (
      .clk         (clk),
      .rst         (rst),
      .in_valid_i  (stage_valid[gi]),
      .in_data_i   (stage_data[gi]),
      .in_ready_o  (stage_ready[gi]),
      .out_valid_o (stage_valid[gi+1]),
      .out_data_o  (stage_data[gi+1]),
      .out_ready_i (stage_ready[gi+1])
    );
  end

endmodule

// File: tb/tb_gmm_subtract_w_sort_pipe.sv
// Randomized and directed checks of the weight-sort pipe against a stable-sort
// reference model and a FIFO scoreboard.
module tb_gmm_subtract_w_sort_pipe;
  import gmm_structures::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gmm_subtract_w_sort_pipe_if snk_if ();
  gmm_subtract_w_sort_pipe_if src_if ();

  gmm_subtract_w_sort_pipe #(.DATA_WIDTH(153)) dut (
    .clk (clk),
    .rst (rst),
    .snk (snk_if),
    .src (src_if)
  );

  int checks = 0;
  int passed = 0;
  int n_acc  = 0;
  int n_out  = 0;
  int cyc    = 0;
  mega_data_t exp_q[$];
  bit         prev_stall = 0;
  mega_data_t prev_data;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input string act, input string req);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: got %s, expected %s", name, act, req);
  endtask

  // Reference: stable sort of the live slots by weight (descending), then
  // each index field is mapped to the position its cluster ended up in.
  function automatic mega_data_t sort_model(input mega_data_t x);
    mega_data_t y;
    int n;
    int perm[3];
    int pos[4];
    int tmp;
    y = x;
    n = int'(x.in.clusters_num);
    for (int k = 0; k < 3; k++) perm[k] = k;
    for (int a = 1; a < n; a++) begin
      int b = a;
      while (b > 0) begin
        if (x.mem_w[perm[b]] > x.mem_w[perm[b-1]]) begin
          tmp = perm[b]; perm[b] = perm[b-1]; perm[b-1] = tmp;
          b--;
        end else break;
      end
    end
    for (int k = 0; k < 3; k++) begin
      y.mem_w[k]     = x.mem_w[perm[k]];
      y.mem_var[k]   = x.mem_var[perm[k]];
      y.mem_color[k] = x.mem_color[perm[k]];
      y.vars[k]      = x.vars[perm[k]];
      pos[perm[k]]   = k;
    end
    pos[3] = 3;
    y.var_min_idx = cidx_t'(pos[x.var_min_idx]);
    y.var_max_idx = cidx_t'(pos[x.var_max_idx]);
    y.p_max_idx   = cidx_t'(pos[x.p_max_idx]);
    return y;
  endfunction

  function automatic mega_data_t rand_beat(input int n);
    mega_data_t x;
    x.in.pixel        = PIX_W'($urandom);
    x.in.clusters_num = 2'(n);
    for (int k = 0; k < 3; k++) begin
      x.mem_w[k]     = ($urandom_range(0, 1) == 1) ? W_W'($urandom_range(0, 3)) : W_W'($urandom);
      x.mem_var[k]   = VAR_W'($urandom);
      x.mem_color[k] = COLOR_W'($urandom);
      x.vars[k]      = VAR_W'($urandom);
    end
    x.var_min_idx = cidx_t'($urandom_range(0, 3));
    x.var_max_idx = cidx_t'($urandom_range(0, 3));
    x.p_max_idx   = cidx_t'($urandom_range(0, 3));
    x.var_min     = VAR_W'($urandom);
    x.var_max     = VAR_W'($urandom);
    x.is_matched  = 1'($urandom);
    x.B           = B_W'($urandom);
    return x;
  endfunction

  // Scoreboard: transfers are sampled on the falling edge, before the rising edge that commits them.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk(src_if.valid === 1'b1 && src_if.data === prev_data, "hold_stable",
            $sformatf("v=%0b d=%h", src_if.valid, src_if.data), $sformatf("v=1 d=%h", prev_data));
      if (src_if.valid && src_if.ready) begin
        n_out++;
        if (exp_q.size() == 0)
          chk(1'b0, "unexpected_beat", $sformatf("%h", src_if.data), "no beat");
        else begin
          mega_data_t e;
          e = exp_q.pop_front();
          chk(src_if.data === e, "sorted_beat", $sformatf("%h", src_if.data), $sformatf("%h", e));
        end
      end
      if (snk_if.valid && snk_if.ready) begin
        n_acc++;
        exp_q.push_back(sort_model(snk_if.data));
      end
      prev_stall = src_if.valid && !src_if.ready;
      prev_data  = src_if.data;
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic send_beat(input mega_data_t x);
    int t;
    snk_if.valid = 1'b1;
    snk_if.data  = x;
    t = 0;
    @(negedge clk);
    while (!snk_if.ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!snk_if.ready) chk(1'b0, "accept_timeout", "ready low", "ready high");
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input mega_data_t x, input mega_data_t e, input string name);
    int lat;
    chk(sort_model(x) === e, {name, "_model"}, $sformatf("%h", sort_model(x)), $sformatf("%h", e));
    send_beat(x);
    snk_if.valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!src_if.valid && lat < 20);
    chk(lat == 3, {name, "_latency"}, $sformatf("%0d", lat), "3");
    chk(src_if.data === e, {name, "_data"}, $sformatf("%h", src_if.data), $sformatf("%h", e));
    @(posedge clk);
    #1;
  endtask

  initial begin
    mega_data_t x, e;
    bit done;
    int a0, c0, o0;

    snk_if.valid = 1'b0;
    snk_if.data  = '0;
    src_if.ready = 1'b1;
    @(negedge clk);
    chk(src_if.valid === 1'b0, "reset_valid", $sformatf("%0b", src_if.valid), "0");
    chk(src_if.data === '0, "reset_data", $sformatf("%h", src_if.data), "0");
    chk(snk_if.ready === 1'b1, "reset_ready", $sformatf("%0b", snk_if.ready), "1");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // Sort with index remap
    x = '0;
    x.in.pixel = 6'd17; x.in.clusters_num = 2'd3;
    x.mem_w[0] = 16'd10; x.mem_w[1] = 16'd50; x.mem_w[2] = 16'd30;
    x.mem_var[0] = 8'd1; x.mem_var[1] = 8'd2; x.mem_var[2] = 8'd3;
    x.mem_color[0] = 8'd4; x.mem_color[1] = 8'd5; x.mem_color[2] = 8'd6;
    x.vars[0] = 8'd7; x.vars[1] = 8'd8; x.vars[2] = 8'd9;
    x.var_min_idx = 2'd1; x.var_max_idx = 2'd2; x.p_max_idx = 2'd0;
    x.var_min = 8'd11; x.var_max = 8'd99; x.is_matched = 1'b1; x.B = 2'd2;
    e = x;
    e.mem_w[0] = 16'd50; e.mem_w[1] = 16'd30; e.mem_w[2] = 16'd10;
    e.mem_var[0] = 8'd2; e.mem_var[1] = 8'd3; e.mem_var[2] = 8'd1;
    e.mem_color[0] = 8'd5; e.mem_color[1] = 8'd6; e.mem_color[2] = 8'd4;
    e.vars[0] = 8'd8; e.vars[1] = 8'd9; e.vars[2] = 8'd7;
    e.var_min_idx = 2'd0; e.var_max_idx = 2'd1; e.p_max_idx = 2'd2;
    run_single(x, e, "sort_remap");

    // Tie plus dead slot holding the heaviest weight
    x = rand_beat(2);
    x.mem_w[0] = 16'd20; x.mem_w[1] = 16'd20; x.mem_w[2] = 16'd200;
    x.var_min_idx = 2'd0; x.var_max_idx = 2'd2; x.p_max_idx = 2'd1;
    run_single(x, x, "tie_dead");

    // n=2 with a real swap: only pair (0,1) moves, slot 2 untouched
    x = rand_beat(2);
    x.mem_w[0] = 16'd5; x.mem_w[1] = 16'd9; x.mem_w[2] = 16'd500;
    x.var_min_idx = 2'd1; x.var_max_idx = 2'd2; x.p_max_idx = 2'd3;
    e = x;
    e.mem_w[0] = 16'd9; e.mem_w[1] = 16'd5;
    e.mem_var[0] = x.mem_var[1]; e.mem_var[1] = x.mem_var[0];
    e.mem_color[0] = x.mem_color[1]; e.mem_color[1] = x.mem_color[0];
    e.vars[0] = x.vars[1]; e.vars[1] = x.vars[0];
    e.var_min_idx = 2'd0;
    run_single(x, e, "pair01_only");

    // Passthrough
    x = rand_beat(1);
    x.mem_w[1] = 16'hFFFF; x.mem_w[0] = 16'd0;
    run_single(x, x, "passthrough");

    // Back-to-back throughput
    c0 = cyc;
    for (int i = 0; i < 10; i++) send_beat(rand_beat(3));
    snk_if.valid = 1'b0;
    chk(cyc - c0 == 10, "throughput", $sformatf("%0d cycles", cyc - c0), "10 cycles");
    repeat (5) @(posedge clk);
    #1;

    // Backpressure
    src_if.ready = 1'b0;
    a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 5; i++) send_beat(rand_beat(3));
        snk_if.valid = 1'b0;
      end
      begin
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk(n_acc - a0 == 3, "fill_count", $sformatf("%0d", n_acc - a0), "3");
        chk(snk_if.ready === 1'b0, "full_ready", $sformatf("%0b", snk_if.ready), "0");
        @(posedge clk); #1;
        src_if.ready = 1'b1;
        @(negedge clk);
        chk(snk_if.ready === 1'b1, "release_ready", $sformatf("%0b", snk_if.ready), "1");
      end
    join
    repeat (6) @(posedge clk);
    #1;
    chk(n_acc - a0 == 5, "bp_accepts", $sformatf("%0d", n_acc - a0), "5");

    // Bubbles with random downstream readiness
    done = 0;
    fork
      begin
        for (int i = 0; i < 30; i++) begin
          send_beat(rand_beat($urandom_range(0, 3)));
          snk_if.valid = 1'b0;
          @(posedge clk); #1;
        end
        done = 1;
      end
      begin
        while (!done) begin
          src_if.ready = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
        src_if.ready = 1'b1;
      end
    join
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "bubble_drain", $sformatf("%0d pending", exp_q.size()), "0 pending");

    // Reset mid-stream
    send_beat(rand_beat(3));
    send_beat(rand_beat(3));
    snk_if.valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk(src_if.valid === 1'b0, "midrst_valid", $sformatf("%0b", src_if.valid), "0");
    chk(src_if.data === '0, "midrst_data", $sformatf("%h", src_if.data), "0");
    chk(snk_if.ready === 1'b1, "midrst_ready", $sformatf("%0b", snk_if.ready), "1");
    @(posedge clk); #1;
    rst = 1'b1;
    o0 = n_out;
    repeat (8) @(negedge clk);
    chk(n_out == o0, "midrst_no_replay", $sformatf("%0d beats", n_out - o0), "0 beats");

    // Random stream after reset, with ready held high
    for (int i = 0; i < 20; i++) send_beat(rand_beat($urandom_range(0, 3)));
    snk_if.valid = 1'b0;
    for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
    #1;
    chk(exp_q.size() == 0, "final_drain", $sformatf("%0d pending", exp_q.size()), "0 pending");

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
